// File: rtl/unidade_execucao.sv
// rtl/unidade_execucao.sv - execution stage feeding the register-display LCD controller
//
// Purpose: debounces the execute button, latches an 18-bit instruction, runs it
// against a 16 x 16-bit signed register file and hands the result to the LCD
// controller with a held start strobe followed by a quiet gap.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   botao_exec   raw execute pushbutton (active high, asynchronous)
//   instrucao    opcode[17:15] dest[14:11] src1[10:7] src2[6:3] / imm[6:0]
//   saida_op     opcode of the last executed instruction
//   saida_end    register address to display
//   saida_valor  signed value to display
//   sinal_start  start strobe to the LCD controller
//   ocupado      high while a sequence is in progress
module unidade_execucao #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int START_HOLD      = 2_000,
  parameter int GAP_CYCLES      = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        botao_exec,
  input  logic [17:0] instrucao,
  output logic [2:0]  saida_op,
  output logic [3:0]  saida_end,
  output logic [15:0] saida_valor,
  output logic        sinal_start,
  output logic        ocupado
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CMAX = (GAP_CYCLES > START_HOLD) ? GAP_CYCLES : START_HOLD;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DPL  = 3'b111;

  typedef enum logic [2:0] {
    IDLE, DECODE, EXECUTE, WRITEBACK, START, GAP, WAIT_RELEASE
  } state_t;

  state_t state, next_state;

  // Button synchronizer and debouncer
  logic          sync1, sync2;
  logic          deb_level, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic          press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1    <= botao_exec;
      sync2    <= sync1;
      deb_prev <= deb_level;
      if (sync2 != deb_level) begin
        // The DEBOUNCE_CYCLES-th consecutive disagreeing cycle flips the level.
        if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_level <= sync2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = deb_level & ~deb_prev;

  // Sequencer
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state != next_state) begin
        cnt <= '0;
      end else if (state == START || state == GAP) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:         if (press) next_state = DECODE;
      DECODE:       next_state = EXECUTE;
      EXECUTE:      next_state = WRITEBACK;
      WRITEBACK:    next_state = START;
      START:        if (cnt == CW'(START_HOLD - 1)) next_state = GAP;
      GAP:          if (cnt == CW'(GAP_CYCLES - 1)) next_state = WAIT_RELEASE;
      WAIT_RELEASE: if (!deb_level) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Strobe and busy come straight from the state register, so an asynchronous
  // reset drops them in the same cycle.
  assign sinal_start = (state == START);
  assign ocupado     = (state != IDLE);

  // Datapath
  logic [15:0] regs [16];
  logic [17:0] instr_q;
  logic [15:0] op_a, op_b, result_q;
  logic [15:0] alu;

  logic [2:0]  op_q;
  logic [3:0]  dest_q;
  logic [15:0] imm_ext;

  assign op_q    = instr_q[17:15];
  assign dest_q  = instr_q[14:11];
  assign imm_ext = {{9{instr_q[6]}}, instr_q[6:0]};

  // Low 16 bits of a product are identical for signed and unsigned operands.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_LOAD: alu = imm_ext;
      OP_ADD:  alu = op_a + op_b;
      OP_ADDI: alu = op_a + imm_ext;
      OP_SUB:  alu = op_a - op_b;
      OP_SUBI: alu = op_a - imm_ext;
      OP_MUL:  alu = op_a * op_b;
      OP_CLR:  alu = '0;
      OP_DPL:  alu = op_a;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      instr_q     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result_q    <= '0;
      saida_op    <= '0;
      saida_end   <= '0;
      saida_valor <= '0;
    end else begin
      case (state)
        DECODE: begin
          instr_q <= instrucao;
          // DPL displays R[dest], so it borrows the first operand port.
          op_a <= (instrucao[17:15] == OP_DPL) ? regs[instrucao[14:11]]
                                               : regs[instrucao[10:7]];
          op_b <= regs[instrucao[6:3]];
        end
        EXECUTE: result_q <= alu;
        WRITEBACK: begin
          saida_op <= op_q;
          if (op_q == OP_CLR) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            saida_end   <= '0;
            saida_valor <= '0;
          end else begin
            if (op_q != OP_DPL) regs[dest_q] <= result_q;
            saida_end   <= dest_q;
            saida_valor <= result_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
